// File: rtl/cv32e40x_register_file_pair_seq.sv
// cv32e40x integer register file with native register-pair reads and writes.
// Dual writes are split across two cycles when only one physical write port
// exists. The pending odd half is forwarded to every read port meanwhile.
// Optional macro CV32E40X_RF_WR_BYPASS_EN: same-cycle write-to-read bypass of
// accepted writes (x0 excluded).

// Per-read-port data select: array, same-cycle bypass, then pending forward.
module cv32e40x_register_file_pair_seq_rd_lane #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter bit BYPASS     = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0]                    addr_i,
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] mem_i,
    input  logic                                     fwd_en_i,
    input  logic [ADDR_WIDTH-1:0]                    fwd_addr_i,
    input  logic [DATA_WIDTH-1:0]                    fwd_data_i,
    input  logic [1:0]                               byp_en_i,
    input  logic [1:0][ADDR_WIDTH-1:0]               byp_addr_i,
    input  logic [1:0][DATA_WIDTH-1:0]               byp_data_i,
    output logic [DATA_WIDTH-1:0]                    data_o
);

    // Later assignments win: forward beats bypass beats array; x0 beats all.
    always_comb begin
        data_o = mem_i[addr_i];
        if (BYPASS) begin
            for (int b = 0; b < 2; b++) begin
                if (byp_en_i[b] && (byp_addr_i[b] == addr_i)) data_o = byp_data_i[b];
            end
        end
        if (fwd_en_i && (fwd_addr_i == addr_i)) data_o = fwd_data_i;
        if (addr_i == '0) data_o = '0;
    end

endmodule

module cv32e40x_register_file_pair_seq #(
    parameter int NUM_READ_PORTS  = 4,
    parameter int NUM_WRITE_PORTS = 1,
    parameter int ADDR_WIDTH      = 5,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         rd_dual_i,
    input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]    rd_addr_i,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]    rd_data_o,
    input  logic                                         wr_valid_i,
    output logic                                         wr_ready_o,
    input  logic                                         wr_dual_i,
    input  logic [ADDR_WIDTH-1:0]                        wr_addr_i,
    input  logic [DATA_WIDTH-1:0]                        wr_data0_i,
    input  logic [DATA_WIDTH-1:0]                        wr_data1_i,
    output logic                                         wr_busy_o
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;
`ifdef CV32E40X_RF_WR_BYPASS_EN
    localparam bit WR_BYPASS = 1'b1;
`else
    localparam bit WR_BYPASS = 1'b0;
`endif

    typedef enum logic {IDLE, SECOND} state_e;

    state_e                                 state_q, state_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]    mem_q;
    logic [ADDR_WIDTH-1:0]                  pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0]                  pend_data_q, pend_data_d;
    logic                                   accept;
    logic [ADDR_WIDTH-1:0]                  even_addr, odd_addr;
    logic [1:0]                             we;
    logic [1:0][ADDR_WIDTH-1:0]             wa;
    logic [1:0][DATA_WIDTH-1:0]             wd;
    logic [1:0]                             byp_en;
    logic [1:0][ADDR_WIDTH-1:0]             byp_addr;
    logic [1:0][DATA_WIDTH-1:0]             byp_data;
    logic                                   fwd_en;
    logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0] lane_addr;

    assign even_addr = {wr_addr_i[ADDR_WIDTH-1:1], 1'b0};
    assign odd_addr  = {wr_addr_i[ADDR_WIDTH-1:1], 1'b1};

    // Handshake, write-port steering and pair serialisation.
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        wr_ready_o  = 1'b0;
        wr_busy_o   = 1'b0;
        accept      = 1'b0;
        we          = '0;
        wa          = '0;
        wd          = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    wr_ready_o = 1'b1;
                    accept     = wr_valid_i;
                    if (accept) begin
                        we[0] = 1'b1;
                        wd[0] = wr_data0_i;
                        if (wr_dual_i) begin
                            wa[0] = even_addr;
                            if (NUM_WRITE_PORTS == 2) begin
                                we[1] = 1'b1;
                                wa[1] = odd_addr;
                                wd[1] = wr_data1_i;
                            end else begin
                                state_d     = SECOND;
                                pend_addr_d = odd_addr;
                                pend_data_d = wr_data1_i;
                            end
                        end else begin
                            wa[0] = wr_addr_i;
                        end
                    end
                end
                SECOND: begin
                    // Port 0 drains the buffered odd half; new requests wait.
                    wr_busy_o   = 1'b1;
                    we[0]       = 1'b1;
                    wa[0]       = pend_addr_q;
                    wd[0]       = pend_data_q;
                    state_d     = IDLE;
                    pend_addr_d = '0;
                    pend_data_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and pending buffer; reset drops any pending odd write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    // Register array update; x0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (we[p] && (wa[p] != '0)) mem_q[wa[p]] <= wd[p];
            end
        end
    end

    // Same-cycle bypass sources: both halves of an accepted write.
    always_comb begin
        byp_en[0]   = accept;
        byp_addr[0] = wr_dual_i ? even_addr : wr_addr_i;
        byp_data[0] = wr_data0_i;
        byp_en[1]   = accept & wr_dual_i;
        byp_addr[1] = odd_addr;
        byp_data[1] = wr_data1_i;
    end

    assign fwd_en = !rst && (state_q == SECOND);

    genvar i;
    generate
        for (i = 0; i < NUM_READ_PORTS; i++) begin : g_rd
            // Upper ports read the partner of the lower ports in dual mode.
            if (i >= 2) begin : g_pair
                assign lane_addr[i] = rd_dual_i ? (rd_addr_i[i-2] ^ ADDR_WIDTH'(1)) : rd_addr_i[i];
            end else begin : g_plain
                assign lane_addr[i] = rd_addr_i[i];
            end

            cv32e40x_register_file_pair_seq_rd_lane #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .BYPASS     (WR_BYPASS)
            ) u_lane (
                .addr_i     (lane_addr[i]),
                .mem_i      (mem_q),
                .fwd_en_i   (fwd_en),
                .fwd_addr_i (pend_addr_q),
                .fwd_data_i (pend_data_q),
                .byp_en_i   (byp_en),
                .byp_addr_i (byp_addr),
                .byp_data_i (byp_data),
                .data_o     (rd_data_o[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_cv32e40x_register_file_pair_seq.sv
// Scoreboard bench: a 1-write-port and a 2-write-port instance share one
// behavioural register model each; expected outputs are queued at stimulus
// time and compared by a separate monitor on the falling edge.
module tb_cv32e40x_register_file_pair_seq;

    localparam int AW = 5, DW = 32, NR = 4, NREG = 32;
`ifdef CV32E40X_RF_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [NR-1:0][DW-1:0] rd;
        logic                  rdy;
        logic                  busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  rd_dual  [2];
    logic [NR-1:0][AW-1:0] rd_addr  [2];
    logic [NR-1:0][DW-1:0] rd_data  [2];
    logic                  wr_valid [2];
    logic                  wr_ready [2];
    logic                  wr_dual  [2];
    logic [AW-1:0]         wr_addr  [2];
    logic [DW-1:0]         wr_d0    [2];
    logic [DW-1:0]         wr_d1    [2];
    logic                  wr_busy  [2];

    cv32e40x_register_file_pair_seq #(.NUM_READ_PORTS(NR), .NUM_WRITE_PORTS(1),
                                      .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_w1 (
        .clk(clk), .rst(rst), .rd_dual_i(rd_dual[0]), .rd_addr_i(rd_addr[0]),
        .rd_data_o(rd_data[0]), .wr_valid_i(wr_valid[0]), .wr_ready_o(wr_ready[0]),
        .wr_dual_i(wr_dual[0]), .wr_addr_i(wr_addr[0]), .wr_data0_i(wr_d0[0]),
        .wr_data1_i(wr_d1[0]), .wr_busy_o(wr_busy[0]));

    cv32e40x_register_file_pair_seq #(.NUM_READ_PORTS(NR), .NUM_WRITE_PORTS(2),
                                      .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_w2 (
        .clk(clk), .rst(rst), .rd_dual_i(rd_dual[1]), .rd_addr_i(rd_addr[1]),
        .rd_data_o(rd_data[1]), .wr_valid_i(wr_valid[1]), .wr_ready_o(wr_ready[1]),
        .wr_dual_i(wr_dual[1]), .wr_addr_i(wr_addr[1]), .wr_data0_i(wr_d0[1]),
        .wr_data1_i(wr_d1[1]), .wr_busy_o(wr_busy[1]));

    // Reference model: register contents plus the not-yet-written odd half.
    logic [DW-1:0] mem    [2][NREG];
    int            pend_a [2];
    logic [DW-1:0] pend_d [2];
    bit            acc    [2];

    exp_t q0[$], q1[$];
    int   n_chk = 0, n_fail = 0;

    function automatic logic [DW-1:0] exp_read(int d, logic [AW-1:0] a);
        logic [AW-1:0] ev;
        bit            taken;
        ev    = {wr_addr[d][AW-1:1], 1'b0};
        taken = !rst && wr_valid[d] && (pend_a[d] < 0);
        if (a == 0) return '0;
        if (rst) return mem[d][a];
        if (pend_a[d] == int'(a)) return pend_d[d];
        if (BYP && taken) begin
            if (wr_dual[d]) begin
                if (a == ev) return wr_d0[d];
                if (a == (ev | AW'(1))) return wr_d1[d];
            end else if (a == wr_addr[d]) begin
                return wr_d0[d];
            end
        end
        return mem[d][a];
    endfunction

    task automatic drive(int d, bit v, bit du, logic [AW-1:0] wa, logic [DW-1:0] d0,
                         logic [DW-1:0] d1, bit rdu, logic [NR-1:0][AW-1:0] ra);
        exp_t          e;
        logic [AW-1:0] ea;
        wr_valid[d] = v;  wr_dual[d] = du; wr_addr[d] = wa;
        wr_d0[d]    = d0; wr_d1[d]   = d1;
        rd_dual[d]  = rdu; rd_addr[d] = ra;
        e.rdy  = !rst && (pend_a[d] < 0);
        e.busy = !rst && (pend_a[d] >= 0);
        for (int i = 0; i < NR; i++) begin
            ea = (rdu && i >= 2) ? (ra[(i + 2) % 4] ^ AW'(1)) : ra[i];
            e.rd[i] = exp_read(d, ea);
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic rd_only(int d, bit rdu, logic [NR-1:0][AW-1:0] ra);
        drive(d, 1'b0, 1'b0, '0, '0, '0, rdu, ra);
    endtask

    task automatic apply(int d);
        logic [AW-1:0] ev;
        ev     = {wr_addr[d][AW-1:1], 1'b0};
        acc[d] = !rst && wr_valid[d] && (pend_a[d] < 0);
        if (rst) begin
            for (int r = 0; r < NREG; r++) mem[d][r] = '0;
            pend_a[d] = -1;
        end else if (pend_a[d] >= 0) begin
            mem[d][pend_a[d]] = pend_d[d];
            pend_a[d] = -1;
        end else if (acc[d]) begin
            if (wr_dual[d]) begin
                if (ev != 0) mem[d][ev] = wr_d0[d];
                if (d == 1) mem[d][ev | AW'(1)] = wr_d1[d];
                else begin
                    pend_a[d] = int'(ev) + 1;
                    pend_d[d] = wr_d1[d];
                end
            end else if (wr_addr[d] != 0) begin
                mem[d][wr_addr[d]] = wr_d0[d];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        apply(0);
        apply(1);
        #1;
    endtask

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check(int d, exp_t e);
        for (int i = 0; i < NR; i++)
            chk($sformatf("w%0d_rd%0d", d + 1, i), rd_data[d][i], e.rd[i]);
        chk($sformatf("w%0d_ready", d + 1), DW'(wr_ready[d]), DW'(e.rdy));
        chk($sformatf("w%0d_busy", d + 1), DW'(wr_busy[d]), DW'(e.busy));
    endtask

    // Monitor: outputs are combinational, so every queued entry belongs to
    // the cycle whose falling edge follows it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin e = q0.pop_front(); check(0, e); end
            if (q1.size() > 0) begin e = q1.pop_front(); check(1, e); end
        end
    end

    initial begin
        logic [NR-1:0][AW-1:0] ra;
        bit                    held [2];
        bit                    h_du [2];
        logic [AW-1:0]         h_a  [2];
        logic [DW-1:0]         h_d0 [2], h_d1 [2];

        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < NREG; r++) mem[d][r] = '0;
            pend_a[d] = -1; pend_d[d] = '0; acc[d] = 1'b0; held[d] = 1'b0;
            h_du[d] = 1'b0; h_a[d] = '0; h_d0[d] = '0; h_d1[d] = '0;
            wr_valid[d] = 1'b0; wr_dual[d] = 1'b0; wr_addr[d] = '0;
            wr_d0[d] = '0; wr_d1[d] = '0; rd_dual[d] = 1'b0; rd_addr[d] = '0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // All registers zero after reset, ready straight away.
        for (int k = 0; k < 8; k++) begin
            ra = {AW'(4*k+3), AW'(4*k+2), AW'(4*k+1), AW'(4*k)};
            rd_only(0, 1'b0, ra);
            rd_only(1, 1'b0, ra);
            tick();
        end

        // 1W: serialised pair x4/x5. 2W: back-to-back pairs x2/x3, x6/x7.
        ra = {5'd5, 5'd4, 5'd5, 5'd4};
        drive(0, 1'b1, 1'b1, 5'd5, 32'hAAAA0000, 32'h5555FFFF, 1'b0, ra);
        drive(1, 1'b1, 1'b1, 5'd2, 32'h22222222, 32'h33333333, 1'b0, {5'd3, 5'd2, 5'd3, 5'd2});
        tick();
        rd_only(0, 1'b0, ra);
        drive(1, 1'b1, 1'b1, 5'd6, 32'h66666666, 32'h77777777, 1'b0, {5'd3, 5'd2, 5'd3, 5'd2});
        tick();
        rd_only(0, 1'b0, ra);
        rd_only(1, 1'b0, {5'd7, 5'd6, 5'd3, 5'd2});
        tick();

        // Pair x0/x1 and a single write to x0.
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 1'b1, 5'd0, 32'h1, 32'h2, 1'b0, {5'd1, 5'd0, 5'd1, 5'd0});
        tick();
        for (int d = 0; d < 2; d++) rd_only(d, 1'b0, {5'd1, 5'd0, 5'd1, 5'd0});
        tick();
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 1'b0, 5'd0, 32'hDEAD, 32'h0, 1'b0, {5'd1, 5'd0, 5'd1, 5'd0});
        tick();

        // Dual read of x8..x11.
        for (int r = 8; r < 12; r++) begin
            for (int d = 0; d < 2; d++)
                drive(d, 1'b1, 1'b0, AW'(r), 32'h100 + r, 32'h0, 1'b0, {5'd8, 5'd9, 5'd10, 5'd11});
            tick();
        end
        for (int d = 0; d < 2; d++) rd_only(d, 1'b1, {5'd0, 5'd0, 5'd11, 5'd8});
        tick();

        // Same-cycle read of a single write to x7.
        for (int d = 0; d < 2; d++) drive(d, 1'b1, 1'b0, 5'd7, 32'h1234, 32'h0, 1'b0, {5'd7, 5'd7, 5'd7, 5'd7});
        tick();

        // Reset during the second cycle of a 1W pair write to x12/x13.
        drive(0, 1'b1, 1'b1, 5'd12, 32'hC0C0C0C0, 32'hD1D1D1D1, 1'b0, {5'd13, 5'd12, 5'd13, 5'd12});
        rd_only(1, 1'b0, {5'd13, 5'd12, 5'd7, 5'd2});
        tick();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) rd_only(d, 1'b0, {5'd13, 5'd12, 5'd7, 5'd2});
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) rd_only(d, 1'b0, {5'd13, 5'd12, 5'd7, 5'd2});
        tick();
        for (int d = 0; d < 2; d++) rd_only(d, 1'b0, {5'd13, 5'd12, 5'd5, 5'd4});
        tick();

        // Randomised traffic; requests are held until accepted.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int d = 0; d < 2; d++) begin
                if (!held[d] && ($urandom_range(0, 2) != 0)) begin
                    held[d] = 1'b1;
                    h_du[d] = $urandom_range(0, 1);
                    h_a[d]  = AW'($urandom_range(0, NREG - 1));
                    h_d0[d] = $urandom;
                    h_d1[d] = $urandom;
                end
                for (int i = 0; i < NR; i++) ra[i] = AW'($urandom_range(0, NREG - 1));
                if ($urandom_range(0, 3) == 0 && held[d]) ra[0] = h_a[d];
                drive(d, held[d], h_du[d], h_a[d], h_d0[d], h_d1[d], $urandom_range(0, 1), ra);
            end
            tick();
            for (int d = 0; d < 2; d++) if (acc[d]) held[d] = 1'b0;
        end

        for (int d = 0; d < 2; d++) rd_only(d, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
